instruction_cache: RTL and testbench
====================================

Name: instruction_cache

Overview:
- Direct-mapped instruction cache between the program counter and instruction memory.
- Takes the fetch address from the PC and returns the 32-bit instruction.
- Asserts busywait to freeze the PC on a miss, and refills a 4-word block from memory through a read handshake.

Parameters:
- ADDR_W, 10, byte-address width used for the fetch address.
- NUM_BLOCKS, 8, cache lines; must be a power of 2.
- WORDS_PER_BLOCK, 4, 32-bit words per line; fixes the memory data width at 128.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset.
- read  input  1  fetch request; CPU holds it low while the PC holds its post-reset value (-4).
- address  input  ADDR_W  fetch byte address (PC[ADDR_W-1:0]); bits [1:0] are ignored.
- instruction  output  32  fetched instruction word.
- busywait  output  1  stall to the PC; high = hold the PC.
- mem_read  output  1  block read request to instruction memory.
- mem_address  output  ADDR_W-4  block address {tag,index}.
- mem_readdata  input  128  refill block; word0 is in bits [31:0].
- mem_busywait  input  1  memory busy; low on an edge while mem_read is high = data valid.

Behaviour:
- Address split (defaults):
  - offset = address[3:2]
  - index = address[6:4]
  - tag = address[9:7]
- Storage per line: valid bit, 3-bit tag, 128-bit data.
- hit = read && valid[index] && tag_store[index]==tag.
- instruction = data word selected by offset; combinational, available in the same cycle as the address.
  - Value is don't-care when not a hit.
- States:
  - IDLE: mem_read=0. busywait = read && !hit (combinational). On a miss, go to MEM_READ at the next edge.
  - MEM_READ: mem_read=1, mem_address = {tag,index} of the current address, busywait=1. Stay while mem_busywait=1. On an edge with mem_busywait=0, go to UPDATE.
  - UPDATE: busywait=1, mem_read=0. At the edge leaving UPDATE:
    - data[index] <= mem_readdata
    - tag_store[index] <= tag
    - valid[index] <= 1
    - state -> IDLE
- Miss penalty = memory latency + 2 cycles (MEM_READ entry + UPDATE). The access after UPDATE is a hit.
- The address is stable during a stall because busywait holds the PC; no address is latched.
- read=0 in IDLE: busywait=0, no refill started.
- read falling while in MEM_READ/UPDATE: the refill still completes.
- RESET=1 at an edge:
  - all valid bits <= 0; state <= IDLE.
  - Tags and data are not cleared.
- While RESET=1, busywait and mem_read are forced to 0 combinationally, so the PC reset is never blocked.
- Reset mid-refill: the line is not written; the memory request drops in the same cycle RESET rises.
- Identical tag/index re-miss cannot occur in IDLE (the line is already valid after UPDATE).
- Back-to-back misses to different lines each take a full refill.
- Same index, different tag: the line is replaced.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- When defined, adds two outputs:
  - hit_count[31:0]: increments on each edge in IDLE with a hit and no RESET.
  - miss_count[31:0]: increments on each IDLE→MEM_READ transition.
- Both counters clear on RESET and wrap modulo 2^32.
- When not defined, neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package (icache_pkg) holds:
  - state encoding constants: IDLE=2'd0, MEM_READ=2'd1, UPDATE=2'd2
  - field widths: OFFSET_W=2, INDEX_W=3, TAG_W=3
  - BLOCK_W=128
- One natural sub-module, icache_word_select: a 4:1 32-bit mux from the 128-bit line to instruction, driven by offset.
- FSM and arrays stay in the top module.

Test Plan:
- Cold miss:
  - Stimulus: RESET, then read=1, address=0x000; memory returns block {w3..w0}={0x33,0x22,0x11,0x00} after 5 busy cycles.
  - Response: busywait=1 for 5+2 cycles; mem_address=0x00; then instruction=0x00 with busywait=0.
- Spatial hits:
  - Stimulus: after the cold miss, addresses 0x004, 0x008, 0x00C.
  - Response: instruction 0x11, 0x22, 0x33 with busywait=0 and mem_read never asserted.
- Conflict:
  - Stimulus: address 0x080 (tag 1, index 0).
  - Response: miss with mem_address=0x08. Then 0x000 misses again (eviction confirmed).
- Reset mid-refill:
  - Stimulus: assert RESET during MEM_READ.
  - Response: mem_read and busywait drop the same cycle; state=IDLE. The next access to that index misses.
- read=0:
  - Stimulus: read=0 with address 0x3FC after reset.
  - Response: busywait=0, mem_read=0 for 10 cycles.
- ICACHE_STATS_EN:
  - Stimulus: run scenarios 1–2.
  - Response: miss_count=1, hit_count=4 (the post-refill hit plus 3 spatial hits). Both read 0 after RESET.

Source files
------------

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared widths and FSM encoding for the instruction cache
package icache_pkg;

   localparam int OFFSET_W = 2;
   localparam int INDEX_W  = 3;
   localparam int TAG_W    = 3;
   localparam int WORD_W   = 32;
   localparam int BLOCK_W  = 128;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_READ = 2'd1,
      UPDATE   = 2'd2
   } state_t;

endpackage

// File: rtl/icache_word_select.sv
// rtl/icache_word_select.sv - picks one 32-bit word out of a cache line
module icache_word_select
   import icache_pkg::*;
(
   input  logic [BLOCK_W-1:0]  i_block,
   input  logic [OFFSET_W-1:0] i_offset,
   output logic [WORD_W-1:0]   o_word
);

   // 4:1 word mux; word0 sits in the low bits of the line
   always_comb begin
      o_word = i_block[31:0];
      case (i_offset)
         2'd0:    o_word = i_block[31:0];
         2'd1:    o_word = i_block[63:32];
         2'd2:    o_word = i_block[95:64];
         2'd3:    o_word = i_block[127:96];
         default: o_word = i_block[31:0];
      endcase
   end

endmodule

// File: rtl/instruction_cache.sv
// rtl/instruction_cache.sv - direct-mapped instruction cache, optional ICACHE_STATS_EN counters
module instruction_cache
   import icache_pkg::*;
#(
   parameter int ADDR_W          = TAG_W + INDEX_W + OFFSET_W + 2,
   parameter int NUM_BLOCKS      = 2 ** INDEX_W,
   parameter int WORDS_PER_BLOCK = 2 ** OFFSET_W
)
(
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          read,
   input  logic [ADDR_W-1:0]             address,
   output logic [31:0]                   instruction,
   output logic                          busywait,
   output logic                          mem_read,
   output logic [ADDR_W-5:0]             mem_address,
   input  logic [32*WORDS_PER_BLOCK-1:0] mem_readdata,
   input  logic                          mem_busywait
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]                   hit_count,
   output logic [31:0]                   miss_count
`endif
);

   localparam int LP_OFF_W = $clog2(WORDS_PER_BLOCK);
   localparam int LP_IDX_W = $clog2(NUM_BLOCKS);
   localparam int LP_TAG_W = ADDR_W - 2 - LP_OFF_W - LP_IDX_W;
   localparam int LP_BLK_W = 32 * WORDS_PER_BLOCK;

   logic [LP_OFF_W-1:0] w_offset;
   logic [LP_IDX_W-1:0] w_index;
   logic [LP_TAG_W-1:0] w_tag;
   logic                w_hit;
   logic                w_unused_byte;

   logic [NUM_BLOCKS-1:0] r_valid;
   logic [LP_TAG_W-1:0]   r_tag  [NUM_BLOCKS];
   logic [LP_BLK_W-1:0]   r_data [NUM_BLOCKS];

   state_t r_state;
   state_t w_next;

   assign w_offset      = address[LP_OFF_W+1:2];
   assign w_index       = address[LP_IDX_W+LP_OFF_W+1:LP_OFF_W+2];
   assign w_tag         = address[ADDR_W-1:LP_IDX_W+LP_OFF_W+2];
   assign w_unused_byte = ^address[1:0];

   assign w_hit = read && r_valid[w_index] && (r_tag[w_index] == w_tag);

   icache_word_select u_word_select (
      .i_block  (r_data[w_index]),
      .i_offset (w_offset),
      .o_word   (instruction)
   );

   // state register; reset returns to IDLE and abandons any refill
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next state: miss starts a refill, memory ready moves to UPDATE, UPDATE writes then idles
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (read && !w_hit) w_next = MEM_READ;
         MEM_READ: if (!mem_busywait)  w_next = UPDATE;
         UPDATE:   w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   // outputs; RESET masks the stall and memory request so the PC can always reset
   always_comb begin
      busywait    = 1'b0;
      mem_read    = 1'b0;
      mem_address = {w_tag, w_index};
      if (!RESET) begin
         case (r_state)
            IDLE:     busywait = read && !w_hit;
            MEM_READ: begin
               busywait = 1'b1;
               mem_read = 1'b1;
            end
            UPDATE:   busywait = 1'b1;
            default:  busywait = 1'b0;
         endcase
      end
   end

   // valid bits are the only storage cleared by reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_valid <= '0;
      end else if (r_state == UPDATE) begin
         r_valid[w_index] <= 1'b1;
      end
   end

   // tag and line data are written only when leaving UPDATE
   always_ff @(posedge CLK) begin
      if (!RESET && r_state == UPDATE) begin
         r_tag[w_index]  <= w_tag;
         r_data[w_index] <= mem_readdata;
      end
   end

`ifdef ICACHE_STATS_EN
   // hit/miss counters, wrapping naturally at 2^32
   always_ff @(posedge CLK) begin
      if (RESET) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (r_state == IDLE) begin
         if (w_hit)              hit_count  <= hit_count + 32'd1;
         if (w_next == MEM_READ) miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// tb/tb_instruction_cache.sv - directed scoreboard bench for instruction_cache
module tb_instruction_cache;

   localparam int LAT = 5;

   logic         CLK = 1'b0;
   logic         RESET;
   logic         read;
   logic [9:0]   address;
   logic [31:0]  instruction;
   logic         busywait;
   logic         mem_read;
   logic [5:0]   mem_address;
   logic [127:0] mem_readdata;
   logic         mem_busywait;
`ifdef ICACHE_STATS_EN
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];
   int mem_cnt = 0;

   instruction_cache dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .read         (read),
      .address      (address),
      .instruction  (instruction),
      .busywait     (busywait),
      .mem_read     (mem_read),
      .mem_address  (mem_address),
      .mem_readdata (mem_readdata),
      .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count    (hit_count),
      .miss_count   (miss_count)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] word_of(input logic [5:0] blk, input logic [1:0] w);
      return {24'd0, 2'd0, blk} * 32'h100 + {30'd0, w} * 32'h11;
   endfunction

   function automatic logic [127:0] block_of(input logic [5:0] blk);
      return {word_of(blk, 2'd3), word_of(blk, 2'd2), word_of(blk, 2'd1), word_of(blk, 2'd0)};
   endfunction

   // memory: ready on the LAT-th cycle of a request
   always @(posedge CLK) begin
      if (mem_read) mem_cnt <= mem_cnt + 1;
      else          mem_cnt <= 0;
   end
   assign mem_busywait = !(mem_read && mem_cnt == LAT - 1);
   assign mem_readdata = block_of(mem_address);

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fetch(input logic [9:0] a, input bit exp_miss, input string tag);
      int  stall;
      bit  saw_mr;
      bit  addr_ok;
      stall   = 0;
      saw_mr  = 0;
      addr_ok = 1;
      address = a;
      read    = 1'b1;
      exp_q.push_back(word_of(a[9:4], a[3:2]));
      #1;
      while (busywait && stall < 200) begin
         if (mem_read) begin
            saw_mr = 1;
            if (mem_address !== a[9:4]) addr_ok = 0;
         end
         stall++;
         @(negedge CLK);
         #1;
      end
      check({tag, "_stall"}, stall, exp_miss ? LAT + 2 : 0);
      check({tag, "_memread"}, saw_mr, exp_miss);
      check({tag, "_memaddr"}, addr_ok, 1);
      check({tag, "_instr"}, instruction, exp_q.pop_front());
      @(negedge CLK);
   endtask

   initial begin
      int n;
      RESET   = 1'b1;
      read    = 1'b1;
      address = 10'h000;
      @(negedge CLK);
      #1;
      check("rst_busy", busywait, 0);
      check("rst_mread", mem_read, 0);
      @(negedge CLK);
      #1;
`ifdef ICACHE_STATS_EN
      check("rst_hits", hit_count, 0);
      check("rst_miss", miss_count, 0);
`endif

      // read low: no stall, no refill
      RESET   = 1'b0;
      read    = 1'b0;
      address = 10'h3FC;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         #1;
         check("idle_busy", busywait, 0);
         check("idle_mread", mem_read, 0);
      end

      fetch(10'h000, 1, "cold");
      fetch(10'h004, 0, "sp1");
      fetch(10'h008, 0, "sp2");
      fetch(10'h00C, 0, "sp3");
`ifdef ICACHE_STATS_EN
      check("stat_hits", hit_count, 4);
      check("stat_miss", miss_count, 1);
`endif

      fetch(10'h080, 1, "conflict");
      fetch(10'h084, 0, "conf_hit");
      fetch(10'h000, 1, "evicted");

      // read falls during refill; line still gets filled
      address = 10'h040;
      read    = 1'b1;
      n = 0;
      #1;
      while (!mem_read && n < 20) begin @(negedge CLK); #1; n++; end
      read = 1'b0;
      n = 0;
      #1;
      while (busywait && n < 50) begin @(negedge CLK); #1; n++; end
      check("dropread_done", busywait, 0);
      fetch(10'h048, 0, "dropread_hit");

      // reset in the middle of a refill
      address = 10'h020;
      read    = 1'b1;
      n = 0;
      #1;
      while (!mem_read && n < 20) begin @(negedge CLK); #1; n++; end
      check("mid_in_memread", mem_read, 1);
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      check("mid_mread_drop", mem_read, 0);
      check("mid_busy_drop", busywait, 0);
      @(negedge CLK);
      #1;
`ifdef ICACHE_STATS_EN
      check("mid_hits_clr", hit_count, 0);
      check("mid_miss_clr", miss_count, 0);
`endif
      RESET = 1'b0;
      fetch(10'h020, 1, "after_rst");
      fetch(10'h000, 1, "valid_clr");
      fetch(10'h024, 0, "after_rst_hit");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
